// File: rtl/snake_input_ctrl_if.sv
// Button/tick/game-state inputs and direction/start/restart outputs of snake_input_ctrl.
// No valid/ready here: game_start and game_rst are single-cycle pulses, the other outputs are levels.
interface snake_input_ctrl_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_start;
  logic       tick;
  logic [1:0] game_state;
  logic [1:0] mov_dir;
  logic       game_start;
  logic       game_rst;
  logic [1:0] phase;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_start, tick, game_state,
    input  mov_dir, game_start, game_rst, phase
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_start, tick, game_state,
    output mov_dir, game_start, game_rst, phase
  );
endinterface

// File: rtl/snake_input_ctrl.sv
// Button front end for snake_controller: sync + debounce, game-phase FSM,
// one-deep pending direction committed on tick with reversal rejection.
module snake_input_ctrl #(
  parameter int         DEBOUNCE_CYCLES = 252000,
  parameter logic [1:0] GAME_STATE_DEAD = 2'b01
) (
  input  logic               clk_25_2,
  input  logic               rst_n,
  snake_input_ctrl_if.slave  ctrl
);

  localparam int NB = 5;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    PH_IDLE = 2'b00,
    PH_RUN  = 2'b01,
    PH_DEAD = 2'b10
  } phase_e;

  // Button index order: 0 up, 1 down, 2 left, 3 right, 4 start.
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] sync1_q, sync2_q;
  logic [NB-1:0] db_q, db_d, db_prev_q;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];
  logic [NB-1:0] press;

  assign btn_raw = {ctrl.btn_start, ctrl.btn_right, ctrl.btn_left,
                    ctrl.btn_down, ctrl.btn_up};

  // db toggles on the cycle the counter would reach DEBOUNCE_CYCLES.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = ~db_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_25_2 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign press = db_q & ~db_prev_q;

  logic       dir_ev;
  logic [1:0] dir_win;
  logic       start_ev;

  assign dir_ev   = |press[3:0];
  assign start_ev = press[4];

  always_comb begin
    dir_win = 2'b00;
    if (press[0])      dir_win = 2'b11;
    else if (press[1]) dir_win = 2'b01;
    else if (press[2]) dir_win = 2'b10;
    else               dir_win = 2'b00;
  end

  phase_e     phase_q, phase_d;
  logic [1:0] mov_dir_q, mov_dir_d;
  logic [1:0] pending_q, pending_d;
  logic       game_start_q, game_start_d;
  logic       game_rst_q, game_rst_d;
  logic [1:0] ref_dir;

  // On a tick cycle the pending direction is what the snake is about to take.
  assign ref_dir = ctrl.tick ? pending_q : mov_dir_q;

  always_comb begin
    phase_d      = phase_q;
    mov_dir_d    = mov_dir_q;
    pending_d    = pending_q;
    game_start_d = 1'b0;
    game_rst_d   = 1'b0;
    case (phase_q)
      PH_IDLE: begin
        mov_dir_d = 2'b00;
        pending_d = 2'b00;
        if (start_ev) begin
          game_start_d = 1'b1;
          phase_d      = PH_RUN;
        end
      end
      PH_RUN: begin
        if (dir_ev && (dir_win != (ref_dir ^ 2'b10))) pending_d = dir_win;
        if (ctrl.tick) mov_dir_d = pending_q;
        if (ctrl.game_state == GAME_STATE_DEAD) phase_d = PH_DEAD;
      end
      PH_DEAD: begin
        if (start_ev) begin
          game_rst_d = 1'b1;
          phase_d    = PH_IDLE;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk_25_2 or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= PH_IDLE;
      mov_dir_q    <= 2'b00;
      pending_q    <= 2'b00;
      game_start_q <= 1'b0;
      game_rst_q   <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      mov_dir_q    <= mov_dir_d;
      pending_q    <= pending_d;
      game_start_q <= game_start_d;
      game_rst_q   <= game_rst_d;
    end
  end

  assign ctrl.mov_dir    = mov_dir_q;
  assign ctrl.game_start = game_start_q;
  assign ctrl.game_rst   = game_rst_q;
  assign ctrl.phase      = phase_q;

endmodule

// File: doc/snake_input_ctrl.md
# snake_input_ctrl

Upstream stage of `snake_controller`: turns raw board buttons into the `mov_dir` and `game_start` signals it consumes. Synchronises and debounces five push-buttons, runs a small game-phase FSM, and buffers one pending direction. The pending direction is committed on each game tick and 180° reversals are rejected. Also issues a one-cycle `game_rst` request to restart after death.

## Interface
- `DEBOUNCE_CYCLES`, default 252000 (10 ms at 25.2 MHz): consecutive stable cycles required before a debounced level changes; minimum 2.
- `GAME_STATE_DEAD`, default 2'b01: encoding of the dead state on `game_state`.
- `clk_25_2` in 1: single clock for the whole block.
- `rst_n` in 1: reset, asynchronous, active-low.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_start` in 1 each: raw buttons, active-high, asynchronous to `clk_25_2`, bouncing.
- `tick` in 1: one-cycle pulse in `clk_25_2`, one per snake step.
- `game_state` in 2: game state from `snake_controller`.
- `mov_dir` out 2: committed direction. 00 = right, 01 = down, 10 = left, 11 = up.
- `game_start` out 1: one-cycle pulse that starts the game.
- `game_rst` out 1: one-cycle restart request.
- `phase` out 2: FSM state for debug. 00 = IDLE, 01 = RUN, 10 = DEAD.

## Operation
- **Synchroniser:** each button passes through a 2-FF synchroniser.
- **Debounce (per button):**
  - Counter of width clog2(DEBOUNCE_CYCLES+1); debounced level `db` starts at 0.
  - While the synchronised level equals `db`, the counter clears to 0.
  - Otherwise it increments. On the cycle it would reach DEBOUNCE_CYCLES, `db` toggles and the counter clears.
- **Press event:** rising edge of `db` (`db` = 1 and its previous registered value = 0). Falling edges are ignored.
- **Direction priority:** when several direction events occur in the same cycle, priority is up > down > left > right. Only the winner is considered.
- **Opposite direction:** `d ^ 2'b10`.
- **FSM:**
  - **IDLE:**
    - `mov_dir` and `pending` are forced to 00.
    - Direction events and `tick` are ignored.
    - A start event pulses `game_start` for one cycle, then the FSM moves to RUN.
  - **RUN:**
    - A direction event with winner d loads `pending` ← d, unless d is opposite of the reference direction. A rejected event leaves `pending` unchanged.
    - Reference direction = `pending` when `tick` is high in the same cycle, otherwise `mov_dir`.
    - `tick` loads `mov_dir` ← `pending`. The commit uses the `pending` value from before this cycle's event, so a press coinciding with `tick` takes effect at the following tick.
    - A later accepted event before the tick overwrites the earlier one (last wins).
    - Start events are ignored.
    - `game_state == GAME_STATE_DEAD`, sampled every cycle, moves the FSM to DEAD. `tick` in that same cycle is still committed.
  - **DEAD:**
    - `mov_dir` holds.
    - Direction events and `tick` are ignored.
    - A start event pulses `game_rst` for one cycle, then the FSM moves to IDLE, whose forcing clears `mov_dir` and `pending` to 00 on the next cycle.
- `game_start` and `game_rst` are never high in the same cycle.
- **Reset (`rst_n` low, any time):** synchronisers, `db`, counters, edge registers, `pending`, and `mov_dir` go to 0. `game_start` = 0, `game_rst` = 0, `phase` = IDLE. Any in-progress debounce is discarded.

## Timing
- All state is registered on the `clk_25_2` rising edge. Outputs come straight from registers with no combinational path from inputs.
- A raw button rising at edge 0 and held clean produces:
  - sync high after edge 2;
  - `db` high after edge 2+DEBOUNCE_CYCLES;
  - the event registered, i.e. `pending`, `game_start` or `game_rst` updated, after edge 3+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no event.
- Commit latency: `mov_dir` updates on the edge that samples `tick` high, visible in the cycle after the `tick` pulse.
- Minimum press-to-`mov_dir` latency is DEBOUNCE_CYCLES+4 edges, when `tick` arrives in the first cycle after `pending` updates.
- The DEAD transition is visible on `phase` one cycle after `game_state` shows DEAD.

## Test plan
- **Start:** DEBOUNCE_CYCLES = 4; reset, hold `btn_start` high 10 cycles → single `game_start` pulse exactly 7 cycles after the rise; `phase` 00→01; `mov_dir` = 00.
- **Bounce:** in RUN, `btn_down` toggling every 2 cycles for 20 cycles, then held → no event during the bounce, exactly one `pending` = 01 after settling; next `tick` gives `mov_dir` = 01.
- **Reversal:** `mov_dir` = 00, press left → `pending` stays 00. Press up → `pending` = 11. `tick` → `mov_dir` = 11. Press down → rejected.
- **Simultaneous:** up and left events in the same cycle with `mov_dir` = 00 → `pending` = 11. Press coinciding with `tick` → commit uses the old `pending`; the new value commits on the next tick.
- **Death/restart:** `game_state` = 01 → `phase` = 10 next cycle; direction presses ignored; start press → one-cycle `game_rst` pulse; `phase` = 00; `mov_dir` = 00.
- **Reset mid-debounce:** assert `rst_n` low while a button is held with counter = 2 → all outputs 0 immediately. Release reset with the button still held → event after a full DEBOUNCE_CYCLES+3 edges.
